// File: rtl/tqvp_vga_capture_pkg.sv
// Shared definitions for the VGA capture peripheral: register map, field widths,
// FSM state encoding and the no-signal timeout.
package tqvp_vga_capture_pkg;

  localparam int unsigned AddrW = 6;
  localparam int unsigned DataW = 32;

  localparam logic [AddrW-1:0] AddrCtrl   = 6'h00;
  localparam logic [AddrW-1:0] AddrStatus = 6'h04;
  localparam logic [AddrW-1:0] AddrHtime  = 6'h08;
  localparam logic [AddrW-1:0] AddrVtime  = 6'h0C;
  localparam logic [AddrW-1:0] AddrPixcnt = 6'h10;
  localparam logic [AddrW-1:0] AddrProbe  = 6'h14;

  localparam int unsigned HcntW   = 12;
  localparam int unsigned LineW   = 10;
  localparam int unsigned PixW    = 20;
  localparam int unsigned ProbeXW = 11;
  localparam int unsigned RgbW    = 6;
  localparam int unsigned TmoW    = 21;

  // Clocks without a vsync rising edge before the capture is abandoned.
  localparam int unsigned TimeoutMax = (1 << TmoW) - 1;

  typedef enum logic [1:0] {
    StIdle,
    StWaitVsync,
    StMeasure
  } state_e;

endpackage

// File: rtl/tqvp_vga_capture_if.sv
// TinyQV peripheral register bus.
//   master: drives address, data_in, data_write_n, data_read_n
//   slave : drives data_out (combinational readback) and data_ready
interface tqvp_vga_capture_if;
  import tqvp_vga_capture_pkg::*;

  logic [AddrW-1:0] address;
  logic [DataW-1:0] data_in;
  logic [1:0]       data_write_n;
  logic [1:0]       data_read_n;
  logic [DataW-1:0] data_out;
  logic             data_ready;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready
  );

endinterface

// File: rtl/vcap_sync_meter.sv
// Edge detector plus saturating period/width counter for one sync signal.
//   clk, rst_n : clock, async active-low reset
//   clr        : zero counter and measurements (edge tracking keeps running)
//   sync       : sync level
//   tick       : count enable (every clock for hsync, hsync rise for vsync)
//   rise, fall : edge flags, asserted in the cycle the new level appears
//   count      : ticks since the last rising edge, including this cycle
//   period     : count at the latest rising edge (current cycle included)
//   width      : count at the latest falling edge (current cycle included)
module vcap_sync_meter #(
  parameter int unsigned Width = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             sync,
  input  logic             tick,
  output logic             rise,
  output logic             fall,
  output logic [Width-1:0] count,
  output logic [Width-1:0] period,
  output logic [Width-1:0] width
);

  localparam logic [Width-1:0] CntMax = '1;

  logic             sync_q;
  logic [Width-1:0] cnt_q, period_q, width_q;

  assign rise = sync & ~sync_q;
  assign fall = ~sync & sync_q;

  always_comb begin
    // A tick coincident with the rising edge is the first one of the new interval.
    if (rise) begin
      count = {{(Width-1){1'b0}}, tick};
    end else if (tick && (cnt_q != CntMax)) begin
      count = cnt_q + 1'b1;
    end else begin
      count = cnt_q;
    end
    period = rise ? cnt_q : period_q;
    width  = fall ? cnt_q : width_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      width_q  <= '0;
    end else begin
      sync_q <= sync;
      if (clr) begin
        cnt_q    <= '0;
        period_q <= '0;
        width_q  <= '0;
      end else begin
        cnt_q    <= count;
        period_q <= period;
        width_q  <= width;
      end
    end
  end

endmodule

// File: rtl/tqvp_vga_capture.sv
// VGA timing/content capture peripheral for TinyQV.
//   clk, rst_n     : clock, async active-low reset
//   ui_in          : [5:0] RGB222, [6] hsync, [7] vsync (synchronized, active-high)
//   uo_out         : unused, driven 0
//   bus            : register bus (slave side)
//   user_interrupt : irq_en & (done | no_signal)
module tqvp_vga_capture
  import tqvp_vga_capture_pkg::*;
#(
  parameter int unsigned TimeoutLimit = TimeoutMax
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               ui_in,
  output logic [7:0]               uo_out,
  tqvp_vga_capture_if.slave        bus,
  output logic                     user_interrupt
);

  localparam logic [TmoW-1:0] TmoLimit = TmoW'(TimeoutLimit);
  localparam logic [PixW-1:0] PixMax   = '1;

  state_e             state_q, state_d;
  logic               continuous_q, continuous_d, irq_en_q, irq_en_d;
  logic               done_q, done_d, no_signal_q, no_signal_d;
  logic [DataW-1:0]   htime_q, htime_d, vtime_q, vtime_d;
  logic [PixW-1:0]    pixcnt_q, pixcnt_d, pix_q, pix_d;
  logic [ProbeXW-1:0] probe_x_q, probe_x_d;
  logic [LineW-1:0]   probe_y_q, probe_y_d;
  logic [RgbW-1:0]    probe_rgb_q, probe_rgb_d;
  logic               probe_valid_q, probe_valid_d, probe_seen_q, probe_seen_d;
  logic [TmoW-1:0]    tmo_q, tmo_d;

  logic               h_rise, h_fall, v_rise, v_fall;
  logic [HcntW-1:0]   h_count, h_period, h_width, hcnt;
  logic [LineW-1:0]   v_count, v_period, v_width, line;
  logic               wr, start, ctrl_wr, stat_wr, probe_wr, close, timeout, probe_hit;
  logic [RgbW-1:0]    rgb;
  logic               unused_bus;

  assign rgb = ui_in[RgbW-1:0];

  vcap_sync_meter #(.Width(HcntW)) u_hsync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .sync   (ui_in[6]),
    .tick   (1'b1),
    .rise   (h_rise),
    .fall   (h_fall),
    .count  (h_count),
    .period (h_period),
    .width  (h_width)
  );

  vcap_sync_meter #(.Width(LineW)) u_vsync (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (start),
    .sync   (ui_in[7]),
    .tick   (h_rise),
    .rise   (v_rise),
    .fall   (v_fall),
    .count  (v_count),
    .period (v_period),
    .width  (v_width)
  );

  // Meter counts include the edge cycle, so position indices are one less.
  assign hcnt = h_count - 1'b1;
  assign line = v_count - 1'b1;

  assign wr       = (bus.data_write_n != 2'b11);
  assign ctrl_wr  = wr && (bus.address == AddrCtrl);
  assign stat_wr  = wr && (bus.address == AddrStatus);
  assign probe_wr = wr && (bus.address == AddrProbe);
  assign start    = ctrl_wr && bus.data_in[0];
  assign close    = (state_q == StMeasure) && v_rise && !start;
  assign timeout  = (state_q != StIdle) && !v_rise && !start && (tmo_q == TmoLimit);
  // The closing-edge cycle already belongs to the next frame.
  assign probe_hit = (state_q == StMeasure) && !v_rise && !probe_seen_q &&
                     (line == probe_y_q) && (hcnt == {1'b0, probe_x_q});

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:      ;
      StWaitVsync: if (v_rise) state_d = StMeasure;
                   else if (timeout) state_d = StIdle;
      StMeasure:   if (v_rise) state_d = continuous_q ? StMeasure : StIdle;
                   else if (timeout) state_d = StIdle;
      default:     state_d = StIdle;
    endcase
    if (start) state_d = StWaitVsync;
  end

  always_comb begin
    continuous_d  = continuous_q;
    irq_en_d      = irq_en_q;
    done_d        = done_q;
    no_signal_d   = no_signal_q;
    htime_d       = htime_q;
    vtime_d       = vtime_q;
    pixcnt_d      = pixcnt_q;
    pix_d         = pix_q;
    probe_x_d     = probe_x_q;
    probe_y_d     = probe_y_q;
    probe_rgb_d   = probe_rgb_q;
    probe_valid_d = probe_valid_q;
    probe_seen_d  = probe_seen_q;
    tmo_d         = (v_rise || start || (state_q == StIdle)) ? '0 : tmo_q + 1'b1;

    if (ctrl_wr) begin
      continuous_d = bus.data_in[1];
      irq_en_d     = bus.data_in[2];
    end
    if (probe_wr) begin
      probe_x_d = bus.data_in[10:0];
      probe_y_d = bus.data_in[25:16];
    end
    // Set events are applied after clears so a coincident set wins.
    if (stat_wr && bus.data_in[1]) done_d = 1'b0;
    if (stat_wr && bus.data_in[2]) no_signal_d = 1'b0;
    if (timeout) no_signal_d = 1'b1;

    if ((state_q == StMeasure) && (rgb != '0) && (pix_q != PixMax)) pix_d = pix_q + 1'b1;
    if (probe_hit) begin
      probe_rgb_d   = rgb;
      probe_valid_d = 1'b1;
      probe_seen_d  = 1'b1;
    end

    if (close) begin
      htime_d      = {4'b0, h_width, 4'b0, h_period};
      vtime_d      = {6'b0, v_width, 6'b0, v_period};
      pixcnt_d     = pix_q;
      pix_d        = '0;
      probe_seen_d = 1'b0;
      done_d       = 1'b1;
    end

    if (start) begin
      done_d        = 1'b0;
      no_signal_d   = 1'b0;
      probe_valid_d = 1'b0;
      probe_seen_d  = 1'b0;
      pix_d         = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      continuous_q  <= 1'b0;
      irq_en_q      <= 1'b0;
      done_q        <= 1'b0;
      no_signal_q   <= 1'b0;
      htime_q       <= '0;
      vtime_q       <= '0;
      pixcnt_q      <= '0;
      pix_q         <= '0;
      probe_x_q     <= '0;
      probe_y_q     <= '0;
      probe_rgb_q   <= '0;
      probe_valid_q <= 1'b0;
      probe_seen_q  <= 1'b0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      continuous_q  <= continuous_d;
      irq_en_q      <= irq_en_d;
      done_q        <= done_d;
      no_signal_q   <= no_signal_d;
      htime_q       <= htime_d;
      vtime_q       <= vtime_d;
      pixcnt_q      <= pixcnt_d;
      pix_q         <= pix_d;
      probe_x_q     <= probe_x_d;
      probe_y_q     <= probe_y_d;
      probe_rgb_q   <= probe_rgb_d;
      probe_valid_q <= probe_valid_d;
      probe_seen_q  <= probe_seen_d;
      tmo_q         <= tmo_d;
    end
  end

  always_comb begin
    bus.data_out = '0;
    case (bus.address)
      AddrCtrl:   bus.data_out = {29'b0, irq_en_q, continuous_q, 1'b0};
      AddrStatus: bus.data_out = {29'b0, no_signal_q, done_q, (state_q != StIdle)};
      AddrHtime:  bus.data_out = htime_q;
      AddrVtime:  bus.data_out = vtime_q;
      AddrPixcnt: bus.data_out = {12'b0, pixcnt_q};
      AddrProbe:  bus.data_out = {probe_valid_q, 25'b0, probe_rgb_q};
      default:    bus.data_out = '0;
    endcase
  end

  assign bus.data_ready  = 1'b1;
  assign uo_out          = 8'h00;
  assign user_interrupt  = irq_en_q & (done_q | no_signal_q);
  assign unused_bus      = ^{bus.data_read_n, bus.data_in};

endmodule

// File: tb/tb_tqvp_vga_capture.sv
// Directed bench for tqvp_vga_capture: synthetic 40-clock lines, 4-clock hsync,
// 10 lines per frame, 2-line vsync, with hsync and vsync rising together.
module tb_tqvp_vga_capture;
  import tqvp_vga_capture_pkg::*;

  localparam int unsigned Tmo = 3000;

  logic       clk;
  logic       rst_n;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic       user_interrupt;
  int         n_checks;
  int         n_fail;

  tqvp_vga_capture_if bus ();

  tqvp_vga_capture #(.TimeoutLimit(Tmo)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .bus            (bus),
    .user_interrupt (user_interrupt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [5:0] a, input logic [31:0] d);
    bus.address      = a;
    bus.data_in      = d;
    bus.data_write_n = 2'b00;
    tick();
    bus.data_write_n = 2'b11;
  endtask

  task automatic check_reg(input string tag, input logic [5:0] a, input logic [31:0] exp);
    tick();
    bus.address = a;
    #1;
    check_eq(tag, bus.data_out, exp);
  endtask

  // mode 0: black; 1: 0x3F on x=10..14 of lines 0-7; 2: 0x2A only at x=7, line 3
  task automatic run_frames(input int nframes, input int mode);
    for (int f = 0; f < nframes; f++) begin
      for (int ln = 0; ln < 10; ln++) begin
        for (int x = 0; x < 40; x++) begin
          logic [5:0] rgb;
          rgb = 6'h00;
          if (mode == 1 && ln < 8 && x >= 10 && x < 15) rgb = 6'h3F;
          if (mode == 2 && ln == 3 && x == 7) rgb = 6'h2A;
          ui_in = {(ln < 2), (x < 4), rgb};
          tick();
        end
      end
    end
    ui_in = 8'h00;
  endtask

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst_n            = 1'b0;
    ui_in            = 8'h00;
    bus.address      = '0;
    bus.data_in      = '0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset state
    check_reg("rst_ctrl", AddrCtrl, 32'h0);
    check_reg("rst_status", AddrStatus, 32'h0);
    check_reg("rst_htime", AddrHtime, 32'h0);
    check_reg("rst_probe", AddrProbe, 32'h0);
    check_eq("rst_irq", {31'b0, user_interrupt}, 32'h0);
    check_eq("uo_out", {24'b0, uo_out}, 32'h0);
    check_eq("data_ready", {31'b0, bus.data_ready}, 32'h1);

    // Single-shot timing measurement
    bus_write(AddrCtrl, 32'h1);
    check_reg("t1_busy", AddrStatus, 32'h1);
    run_frames(3, 0);
    check_reg("t1_htime", AddrHtime, 32'h0004_0028);
    check_reg("t1_vtime", AddrVtime, 32'h0002_000A);
    check_reg("t1_status", AddrStatus, 32'h2);
    check_reg("t1_pixcnt", AddrPixcnt, 32'h0);
    check_eq("t1_irq_off", {31'b0, user_interrupt}, 32'h0);
    check_reg("t1_unmapped18", 6'h18, 32'h0);
    check_reg("t1_unmapped0a", 6'h0A, 32'h0);

    // Pixel count and interrupt
    bus_write(AddrCtrl, 32'h5);
    check_eq("t2_irq_cleared_by_start", {31'b0, user_interrupt}, 32'h0);
    check_reg("t2_ctrl", AddrCtrl, 32'h4);
    run_frames(3, 1);
    check_reg("t2_pixcnt", AddrPixcnt, 32'd40);
    check_eq("t2_irq", {31'b0, user_interrupt}, 32'h1);
    bus_write(AddrStatus, 32'h4);
    check_eq("t2_irq_other_bit", {31'b0, user_interrupt}, 32'h1);
    bus_write(AddrStatus, 32'h2);
    check_eq("t2_irq_clr", {31'b0, user_interrupt}, 32'h0);
    check_reg("t2_status_clr", AddrStatus, 32'h0);

    // Probe
    bus_write(AddrProbe, 32'h0003_0007);
    bus_write(AddrCtrl, 32'h1);
    check_reg("t3_probe_pre", AddrProbe, 32'h0);
    run_frames(3, 2);
    check_reg("t3_probe", AddrProbe, 32'h8000_002A);
    check_reg("t3_pixcnt", AddrPixcnt, 32'd1);

    // No-signal timeout
    bus_write(AddrCtrl, 32'h5);
    repeat (Tmo - 30) tick();
    check_reg("t4_before", AddrStatus, 32'h1);
    repeat (40) tick();
    check_reg("t4_status", AddrStatus, 32'h4);
    check_reg("t4_htime_kept", AddrHtime, 32'h0004_0028);
    check_eq("t4_irq", {31'b0, user_interrupt}, 32'h1);

    // Continuous mode, then reset mid-measure
    bus_write(AddrCtrl, 32'h3);
    run_frames(3, 0);
    check_reg("t5_cont_status", AddrStatus, 32'h3);
    check_reg("t5_vtime", AddrVtime, 32'h0002_000A);
    rst_n = 1'b0;
    check_reg("t5_rst_status", AddrStatus, 32'h0);
    check_reg("t5_rst_ctrl", AddrCtrl, 32'h0);
    check_reg("t5_rst_htime", AddrHtime, 32'h0);
    check_reg("t5_rst_vtime", AddrVtime, 32'h0);
    check_reg("t5_rst_pixcnt", AddrPixcnt, 32'h0);
    check_reg("t5_rst_probe", AddrProbe, 32'h0);
    check_eq("t5_rst_irq", {31'b0, user_interrupt}, 32'h0);
    tick();
    rst_n = 1'b1;
    run_frames(2, 1);
    check_reg("t5_no_restart", AddrStatus, 32'h0);
    check_reg("t5_no_publish", AddrHtime, 32'h0);
    check_reg("t5_no_pix", AddrPixcnt, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tqvp_vga_capture.md
TQVP_VGA_CAPTURE -- requirements
Module: tqvp_vga_capture

Interface
REQ-001 clk  input  1  TinyQV project clock (nominally 64 MHz); sole clock.
REQ-002 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 ui_in  input  8  video input, already synchronized: [5:0] RGB (2-2-2, R in [5:4]), [6] hsync, [7] vsync; syncs active-high.
REQ-004 uo_out  output  8  tied to 8'h00.
REQ-005 address  input  6  register byte address.
REQ-006 data_in  input  32  write data; any write width updates the full register from data_in.
REQ-007 data_write_n  input  2  11 = no write, else write.
REQ-008 data_read_n  input  2  11 = no read; unused otherwise.
REQ-009 data_out  output  32  combinational readback; 0 for unmapped addresses.
REQ-010 data_ready  output  1  constant 1.
REQ-011 user_interrupt  output  1  level interrupt, equal to irq_en AND (done OR no_signal).

Function
REQ-012 Registers:
- 0x00 CTRL: [0] start (self-clearing), [1] continuous, [2] irq_en.
- 0x04 STATUS: [0] busy, [1] done, [2] no_signal; writing 1 to [1] or [2] clears that bit.
- 0x08 HTIME: [11:0] line period (clocks), [27:16] hsync width (clocks).
- 0x0C VTIME: [9:0] lines per frame, [25:16] vsync width (lines).
- 0x10 PIXCNT: [19:0] non-black pixel count.
- 0x14 PROBE: write sets [10:0] probe_x and [25:16] probe_y; read returns [5:0] captured RGB and [31] valid.
REQ-013 Edge detection SHALL compare ui_in against a one-cycle-delayed copy; a rising edge is flagged in the cycle the new level appears on ui_in.
REQ-014 FSM states: IDLE, WAIT_VSYNC, MEASURE.
- IDLE -> WAIT_VSYNC on a start write.
- WAIT_VSYNC -> MEASURE on a vsync rising edge.
- MEASURE -> IDLE on the next vsync rising edge when continuous=0; MEASURE -> MEASURE when continuous=1.
REQ-015 A start write in any state SHALL restart at WAIT_VSYNC, clear done, no_signal and probe valid, and zero all working counters.
REQ-016 busy SHALL be 1 whenever the state is not IDLE.
REQ-017 Horizontal counter hcnt (12 bit) SHALL be 0 in the hsync-rising-edge cycle, increment otherwise, and saturate at 4095.
- Line period = hcnt+1 sampled at the next hsync rising edge.
- Hsync width = hcnt+1 sampled at the hsync falling edge.
REQ-018 Line counter (10 bit, saturating at 1023) SHALL count hsync rising edges in [vsync edge, next vsync edge).
- An hsync edge coincident with the opening vsync edge is line 0.
- An hsync edge coincident with the closing vsync edge belongs to the next frame.
REQ-019 Vsync width = line count at the vsync falling edge, measured from the vsync rising edge.
REQ-020 PIXCNT working counter SHALL increment in every MEASURE cycle where RGB != 0, saturating at 20'hFFFFF.
REQ-021 At each closing vsync edge in MEASURE:
- Working values SHALL be copied to HTIME, VTIME and PIXCNT atomically in one cycle.
- done SHALL be set.
- Working counters SHALL be reset for the next frame.
REQ-022 Probe: in MEASURE, when line==probe_y and hcnt==probe_x, RGB SHALL be latched and valid set; only the first match per frame is latched.
REQ-023 A 21-bit timeout counter SHALL clear on every vsync rising edge and count in WAIT_VSYNC/MEASURE.
- On reaching 2^21-1: set no_signal, go to IDLE.
- Published registers SHALL keep their prior values.
REQ-024 A status-clear write coincident with a set event SHALL leave the bit set (set wins).

Reset
REQ-025 While rst_n is low: all registers, counters and flags SHALL be 0, state IDLE, user_interrupt 0, uo_out 8'h00.
REQ-026 Deassertion mid-frame SHALL require a new start write; no partial frame is published.

Structure
REQ-027 A shared package tqvp_vga_capture_pkg SHALL hold register address constants, field widths, the FSM state enum and the timeout constant.
REQ-028 One sub-module, vcap_sync_meter, SHALL implement edge detection plus one period/width counter, instantiated once for hsync and once for vsync.

Verification
REQ-029 Synthetic video: line 40 clk, hsync 4 clk, 10 lines/frame, vsync 2 lines; start, continuous=0 -> HTIME=0x0004_0028, VTIME=0x0002_000A, done=1, busy=0.
REQ-030 Same timing, RGB=0x3F for 5 clk/line on lines 0-7 -> PIXCNT=40; with irq_en=1 user_interrupt=1 until a STATUS write of 0x2.
REQ-031 PROBE written with x=7, y=3; RGB=0x2A only at that point -> PROBE read 0x8000_002A.
REQ-032 Syncs held low after start -> no_signal=1 after 2^21-1 clocks, state IDLE, HTIME unchanged.
REQ-033 Hsync edge in the same cycle as the vsync edge, and rst_n pulsed mid-MEASURE -> line count includes that edge; after reset all reads are 0 and busy=0.
